// File: rtl/ha_pipe.sv
// ha_pipe: WIDTH-bit add of a+b+cin, SEG bits per stage, registered carry chain; `ADD_SUB_EN adds the sub port.
// Latency: STAGES = WIDTH/SEG cycles, one result per cycle.
// Backpressure: whole pipe freezes while out_valid && !out_ready; in_ready = !stall.
module ha_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4,
   localparam int STAGES = WIDTH / SEG
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   logic             stall;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

`ifdef ADD_SUB_EN
   // a - b - cin == a + ~b + ~cin; mode is folded into the operands at entry
   assign b_eff = sub ? ~b : b;
   assign c_eff = sub ? ~cin : cin;
`else
   assign b_eff = b;
   assign c_eff = cin;
`endif

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   // What each stage consumes. Remaining operand bits are shifted down so the
   // active segment always sits at [SEG-1:0]; the partial sum fills from the top.
   logic             v_src [STAGES];
   logic             c_src [STAGES];
   logic [WIDTH-1:0] a_src [STAGES];
   logic [WIDTH-1:0] b_src [STAGES];
   logic [WIDTH-1:0] p_src [STAGES];

   assign v_src[0] = in_valid;
   assign c_src[0] = c_eff;
   assign a_src[0] = a;
   assign b_src[0] = b_eff;
   assign p_src[0] = '0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      logic [SEG:0]     seg_sum;
      logic [WIDTH-1:0] p_nxt;
      logic             vld_q;
      logic             cy_q;
      logic [WIDTH-1:0] sum_q;

      assign seg_sum = {1'b0, a_src[k][SEG-1:0]} + {1'b0, b_src[k][SEG-1:0]}
                     + {{SEG{1'b0}}, c_src[k]};
      assign p_nxt   = (p_src[k] >> SEG) | (WIDTH'(seg_sum[SEG-1:0]) << (WIDTH - SEG));

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (!stall) begin
            vld_q <= v_src[k];
            cy_q  <= seg_sum[SEG];
            sum_q <= p_nxt;
         end
      end

      if (k < STAGES - 1) begin : g_mid
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_src[k] >> SEG;
               b_q <= b_src[k] >> SEG;
            end
         end

         assign v_src[k+1] = vld_q;
         assign c_src[k+1] = cy_q;
         assign a_src[k+1] = a_q;
         assign b_src[k+1] = b_q;
         assign p_src[k+1] = sum_q;
      end else begin : g_last
         logic ovf_q;

         // carry into the MSB is recovered as a^b^sum at that bit
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (!stall) begin
               ovf_q <= a_src[k][SEG-1] ^ b_src[k][SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];
            end
         end

         assign out_valid = vld_q;
         assign s         = sum_q;
         assign cout      = cy_q;
         assign ovf       = ovf_q;
      end
   end

endmodule

// File: tb/tb_ha_pipe.sv
// Bench for ha_pipe: directed scenarios on an 8/4 instance, random regression on 8/4 and 16/4 instances
// against an integer-arithmetic reference model.
module tb_ha_pipe;

   localparam int ST8 = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
   logic        in_ready8, out_valid8, cout8, ovf8;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [7:0]  s8;

   logic        in_valid16 = 1'b0, out_ready16 = 1'b0, cin16 = 1'b0;
   logic        in_ready16, out_valid16, cout16, ovf16;
   logic [15:0] a16 = '0, b16 = '0;
   logic [15:0] s16;

`ifdef ADD_SUB_EN
   logic        sub8 = 1'b0, sub16 = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   ha_pipe #(.WIDTH(8), .SEG(4)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8),
`ifdef ADD_SUB_EN
      .sub(sub8),
`endif
      .out_valid(out_valid8), .out_ready(out_ready8),
      .s(s8), .cout(cout8), .ovf(ovf8)
   );

   ha_pipe #(.WIDTH(16), .SEG(4)) dut16 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .cin(cin16),
`ifdef ADD_SUB_EN
      .sub(sub16),
`endif
      .out_valid(out_valid16), .out_ready(out_ready16),
      .s(s16), .cout(cout16), .ovf(ovf16)
   );

   // Reference: {s[15:0], cout, ovf} from plain signed/unsigned integer arithmetic.
   function automatic logic [17:0] ref_model(input int w, input logic [15:0] x, input logic [15:0] y,
                                             input logic c, input logic sb);
      longint lim, ux, uy, sx, sy, cl, full, sfull;
      logic [17:0] r;
      lim   = longint'(1) << w;
      ux    = longint'(x) & (lim - 1);
      uy    = longint'(y) & (lim - 1);
      sx    = (ux >= lim / 2) ? ux - lim : ux;
      sy    = (uy >= lim / 2) ? uy - lim : uy;
      cl    = c ? longint'(1) : longint'(0);
      if (sb) begin
         full  = ux - uy - cl;
         sfull = sx - sy - cl;
      end else begin
         full  = ux + uy + cl;
         sfull = sx + sy + cl;
      end
      r[17:2] = 16'(full & (lim - 1));
      r[1]    = sb ? (full >= 0) : (full >= lim);
      r[0]    = (sfull >= lim / 2) || (sfull < -(lim / 2));
      return r;
   endfunction

   // Drives one operand pair into dut8 and waits for its result.
   task automatic send_one(input logic [7:0] x, input logic [7:0] y, input logic c,
                           output int lat, output logic [7:0] rs, output logic rc,
                           output logic ro, output logic v_after);
      @(negedge clk);
      a8 = x; b8 = y; cin8 = c; in_valid8 = 1'b1; out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rs = s8; rc = cout8; ro = ovf8;
      @(negedge clk);
      v_after = out_valid8;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({out_valid8, s8, cout8, ovf8, in_ready8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset8: out_valid/s/cout/ovf/in_ready=%b/%h/%b/%b/%b, want 0/00/0/0/1",
                  out_valid8, s8, cout8, ovf8, in_ready8);
      end
      checks++;
      if ({out_valid16, s16, cout16, ovf16, in_ready16} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset16: out_valid/s/cout/ovf/in_ready=%b/%h/%b/%b/%b, want 0/0000/0/0/1",
                  out_valid16, s16, cout16, ovf16, in_ready16);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_add();
      int lat; logic [7:0] rs; logic rc, ro, va;
      send_one(8'h3A, 8'h47, 1'b0, lat, rs, rc, ro, va);
      checks++;
      if (lat !== ST8) begin
         errors++; $display("FAIL basic_latency: got %0d cycles, want %0d", lat, ST8);
      end
      checks++;
      if ({rs, rc, ro} !== {8'h81, 1'b0, 1'b1}) begin
         errors++; $display("FAIL basic_add: s/cout/ovf=%h/%b/%b, want 81/0/1", rs, rc, ro);
      end
      checks++;
      if (va !== 1'b0) begin
         errors++; $display("FAIL basic_single_pulse: out_valid next cycle=%b, want 0", va);
      end
   endtask

   task automatic test_carry_ripple();
      int lat; logic [7:0] rs; logic rc, ro, va;
      send_one(8'hFF, 8'h01, 1'b0, lat, rs, rc, ro, va);
      checks++;
      if ({rs, rc, ro} !== {8'h00, 1'b1, 1'b0}) begin
         errors++; $display("FAIL carry_ff_01: s/cout/ovf=%h/%b/%b, want 00/1/0", rs, rc, ro);
      end
      send_one(8'h0F, 8'h00, 1'b1, lat, rs, rc, ro, va);
      checks++;
      if ({rs, rc, ro} !== {8'h10, 1'b0, 1'b0}) begin
         errors++; $display("FAIL carry_0f_cin: s/cout/ovf=%h/%b/%b, want 10/0/0", rs, rc, ro);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got[$];
      logic [7:0] exp_bp [3];
      logic       pending, extra;
      int         cyc;
      exp_bp = '{8'h02, 8'h04, 8'h06};
      @(negedge clk);
      a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
      @(posedge clk); @(negedge clk);
      a8 = 8'h02; b8 = 8'h02;
      @(posedge clk); @(negedge clk);
      a8 = 8'h03; b8 = 8'h03; out_ready8 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({out_valid8, in_ready8, s8} !== {1'b1, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: out_valid/in_ready/s=%b/%b/%h, want 1/0/02",
                     i, out_valid8, in_ready8, s8);
         end
         @(posedge clk); @(negedge clk);
      end
      out_ready8 = 1'b1;
      pending = 1'b1;
      cyc = 0;
      while (got.size() < 3 && cyc < 20) begin
         #1;
         if (out_valid8 && out_ready8) got.push_back(s8);
         if (in_valid8 && in_ready8) pending = 1'b0;
         @(posedge clk); @(negedge clk);
         if (!pending) in_valid8 = 1'b0;
         cyc++;
      end
      in_valid8 = 1'b0;
      checks++;
      if (got.size() !== 3) begin
         errors++; $display("FAIL bp_count: got %0d results, want 3", got.size());
      end
      for (int i = 0; i < got.size() && i < 3; i++) begin
         checks++;
         if (got[i] !== exp_bp[i]) begin
            errors++; $display("FAIL bp_order[%0d]: s=%h, want %h", i, got[i], exp_bp[i]);
         end
      end
      extra = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (out_valid8) extra = 1'b1;
      end
      checks++;
      if (extra !== 1'b0) begin
         errors++; $display("FAIL bp_duplicate: extra out_valid seen=%b, want 0", extra);
      end
   endtask

   task automatic test_reset_midflight();
      logic seen;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
      @(posedge clk); @(negedge clk);
      a8 = 8'h30; b8 = 8'h40;
      @(posedge clk); @(negedge clk);
      in_valid8 = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid8, s8, cout8, ovf8} !== {1'b0, 8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_async: out_valid/s/cout/ovf=%b/%h/%b/%b, want 0/00/0/0",
                  out_valid8, s8, cout8, ovf8);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready8 = 1'b1;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid8) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL reset_discard: out_valid after reset=%b, want 0", seen);
      end
   endtask

`ifdef ADD_SUB_EN
   task automatic test_subtract();
      int lat; logic [7:0] rs; logic rc, ro, va;
      sub8 = 1'b1;
      send_one(8'h05, 8'h07, 1'b0, lat, rs, rc, ro, va);
      checks++;
      if ({rs, rc} !== {8'hFE, 1'b0}) begin
         errors++; $display("FAIL sub_05_07: s/cout=%h/%b, want FE/0", rs, rc);
      end
      send_one(8'h80, 8'h01, 1'b0, lat, rs, rc, ro, va);
      checks++;
      if ({rs, ro, rc} !== {8'h7F, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sub_80_01: s/ovf/cout=%h/%b/%b, want 7F/1/1", rs, ro, rc);
      end
      sub8 = 1'b0;
   endtask
`endif

   // which=0 drives dut8, which=1 drives dut16; the other instance stays idle.
   task automatic test_random(input int which, input int n_vec);
      logic [17:0] q[$];
      logic [17:0] exp_r, got_r;
      logic [15:0] ra, rb;
      logic        rc, rs, vld, rdy, ov, ir;
      int          acc, got, cyc, w;
      w = (which == 0) ? 8 : 16;
      acc = 0; got = 0; cyc = 0;
      while ((acc < n_vec || got < acc) && cyc < 60000) begin
         @(negedge clk);
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rc  = 1'($urandom);
`ifdef ADD_SUB_EN
         rs  = 1'($urandom);
`else
         rs  = 1'b0;
`endif
         vld = (acc < n_vec) && ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         if (which == 0) begin
            a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc; in_valid8 = vld; out_ready8 = rdy;
`ifdef ADD_SUB_EN
            sub8 = rs;
`endif
         end else begin
            a16 = ra; b16 = rb; cin16 = rc; in_valid16 = vld; out_ready16 = rdy;
`ifdef ADD_SUB_EN
            sub16 = rs;
`endif
         end
         #1;
         if (which == 0) begin
            ov = out_valid8; ir = in_ready8; got_r = {8'h00, s8, cout8, ovf8};
         end else begin
            ov = out_valid16; ir = in_ready16; got_r = {s16, cout16, ovf16};
         end
         if (ov && rdy) begin
            exp_r = (q.size() != 0) ? q.pop_front() : 18'h3FFFF;
            checks++;
            if (got_r !== exp_r) begin
               errors++;
               $display("FAIL random_w%0d[%0d]: {s,cout,ovf}=%h, want %h", w, got, got_r, exp_r);
            end
            got++;
         end
         if (vld && ir) begin
            q.push_back(ref_model(w, ra, rb, rc, rs));
            acc++;
         end
         cyc++;
      end
      checks++;
      if (got !== n_vec || q.size() !== 0) begin
         errors++;
         $display("FAIL random_w%0d_count: results=%0d pending=%0d, want %0d/0", w, got, q.size(), n_vec);
      end
      @(negedge clk);
      in_valid8 = 1'b0; in_valid16 = 1'b0; out_ready8 = 1'b1; out_ready16 = 1'b1;
`ifdef ADD_SUB_EN
      sub8 = 1'b0; sub16 = 1'b0;
`endif
      repeat (6) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_carry_ripple();
      test_back_to_back();
      test_reset_midflight();
`ifdef ADD_SUB_EN
      test_subtract();
`endif
      test_random(0, 10000);
      test_random(1, 3000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ha_pipe.md
# ha_pipe

- Parametrised, pipelined successor to the single-bit half adder.
- Adds two WIDTH-bit operands plus carry-in, computing SEG bits per pipeline stage with a registered carry chain between stages.
- Produces sum, carry-out and signed overflow after a fixed latency, with valid/ready flow control on both sides.
- Sits between operand-producing logic and the datapath result register wherever a wide add would otherwise limit clock rate.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits; must be ≥ 2.
- SEG, 4, bits added per stage; WIDTH must be an exact multiple of SEG.
- STAGES, derived as WIDTH/SEG, not overridden; pipeline depth.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (borrow-in when subtracting).
- sub  in  1  subtract select; present only with ADD_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  sum/difference.
- cout  out  1  carry-out of MSB; in subtract mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- **Transfer rules**
  - Input transfer: in_valid && in_ready on a rising edge.
  - Output transfer: out_valid && out_ready on a rising edge.
- **Pipeline structure**
  - Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of the operands plus the carry registered by stage k-1. Stage 0 uses cin.
  - Each stage registers: a valid bit, the sum bits completed so far, its carry-out, and the not-yet-consumed upper operand bits. Unconsumed bits are delayed in lockstep with the data.
- **Flow control**
  - Global stall: stall = out_valid && !out_ready.
  - While stalled, no stage register changes.
  - in_ready = !stall. This is combinational; in_valid does not feed in_ready.
- **Bubbles**
  - When not stalled, stage 0 loads in_valid (a bubble if 0). Every later stage loads from its predecessor.
  - Bubbles propagate and are not compressed.
- **Arithmetic**
  - s = (a + b + cin) mod 2^WIDTH.
  - cout = bit WIDTH of the full sum.
  - ovf = c[WIDTH-1] ^ c[WIDTH], where c[i] is the carry into bit i.
  - Results are bit-exact for every WIDTH/SEG combination that satisfies the parameter constraints.
- **Reset**
  - Clears all stage valid bits, data and carries.
  - out_valid=0, s=0, cout=0, ovf=0.
  - in_ready=1 once out_valid is 0.
  - A reset mid-operation discards all in-flight results with no partial output.

## Timing
- **Latency:** an input accepted at edge N appears with out_valid=1 after edge N+STAGES−1+1, i.e. STAGES cycles, when there is no stall.
- **Throughput:** one result per cycle.
- **Outputs:**
  - s, cout, ovf and out_valid come directly from the last stage's registers; there is no combinational path from a/b to outputs.
  - s, cout and ovf hold stable while out_valid && !out_ready.
- **Simultaneous events:**
  - Output transfer and input acceptance in the same cycle are permitted; the pipeline advances.
  - With out_ready=0 and out_valid=0, the pipeline still advances because stall is 0.
- **Reset:** asynchronous assertion takes effect immediately; deassertion is used synchronously to clk by the surrounding design.

## Configuration
- **ADD_SUB_EN defined**
  - The sub port exists and is captured with the operands at stage 0.
  - sub=1 computes a − b − cin by using ~b and a carry-in of ~cin.
  - cout=1 means no borrow; ovf is signed subtraction overflow.
- **ADD_SUB_EN undefined**
  - No sub port; add only.
  - No per-stage mode storage, and no b inversion logic.

## Test plan
Configuration for all scenarios: WIDTH=8, SEG=4 (STAGES=2); a bench should also run WIDTH=16, SEG=4.
- **Basic add:** a=8'h3A, b=8'h47, cin=0, out_ready=1 → 2 cycles later s=8'h81, cout=0, ovf=1; out_valid high exactly one cycle.
- **Carry ripple across stage boundary:** a=8'hFF, b=8'h01, cin=0 → s=8'h00, cout=1, ovf=0. Then a=8'h0F, b=8'h00, cin=1 → s=8'h10.
- **Back-pressure:**
  - Stimulus: stream 8'h01+8'h01, 8'h02+8'h02, 8'h03+8'h03 back-to-back; hold out_ready=0 for 3 cycles once out_valid rises.
  - Response: in_ready=0 during the stall; s holds 8'h02 until release; results then appear as 8'h02, 8'h04, 8'h06 in order, with none lost or duplicated.
- **Reset mid-flight:** accept two operands, assert rst before either emerges → out_valid=0, s=0 immediately; no result appears after deassertion.
- **Subtract (ADD_SUB_EN):** a=8'h05, b=8'h07, cin=0, sub=1 → s=8'hFE, cout=0. a=8'h80, b=8'h01, sub=1 → s=8'h7F, ovf=1, cout=1.
- **Random regression:** 10k random a/b/cin vectors (random sub when ADD_SUB_EN is defined) with random out_ready → every output matches the reference arithmetic, in order.
